// File: rtl/decoder_3to8_strobe.sv
// Buffers 3-bit codes in a small FIFO and replays each as a one-hot strobe
// held for HOLD cycles, followed by GAP all-zero cycles.
module decoder_3to8_strobe #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 2,
  parameter int GAP   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_code,
  output logic [7:0]               data,
  output logic                     data_valid,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD - 1);
  localparam logic [GW-1:0] GAP_LD  = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

  logic [2:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q;
  logic [HW-1:0] hold_cnt_q;
  logic [GW-1:0] gap_cnt_q;
  logic [7:0]    data_q;
  logic          data_valid_q;
  logic          busy_q;

  logic       push, pop, has_code;
  logic [2:0] head;
  logic [7:0] head_onehot;

  // Ready depends on registered occupancy only, so a full FIFO never passes through.
  assign in_ready    = !rst && (count_q < FULL);
  assign push        = in_valid && in_ready;
  assign has_code    = (count_q != '0);
  assign head        = mem_q[rd_ptr_q];
  assign head_onehot = 8'(1) << head;

  always_comb begin
    pop = 1'b0;
    case (state_q)
      S_IDLE:  pop = has_code;
      S_DRIVE: pop = (hold_cnt_q == '0) && (GAP == 0) && has_code;
      S_GAP:   pop = (gap_cnt_q == '0) && has_code;
      default: pop = 1'b0;
    endcase
  end

  assign count_d = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      hold_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            data_q       <= head_onehot;
            data_valid_q <= 1'b1;
            hold_cnt_q   <= HOLD_LD;
            busy_q       <= 1'b1;
            state_q      <= S_DRIVE;
          end else begin
            data_q       <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (hold_cnt_q != '0) begin
            hold_cnt_q <= hold_cnt_q - 1'b1;
          end else if (GAP > 0) begin
            data_q       <= '0;
            data_valid_q <= 1'b0;
            gap_cnt_q    <= GAP_LD;
            state_q      <= S_GAP;
          end else if (pop) begin
            // Zero-gap build: next strobe follows with no idle cycle.
            data_q     <= head_onehot;
            hold_cnt_q <= HOLD_LD;
          end else begin
            data_q       <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_cnt_q != '0) begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end else if (pop) begin
            data_q       <= head_onehot;
            data_valid_q <= 1'b1;
            hold_cnt_q   <= HOLD_LD;
            state_q      <= S_DRIVE;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          data_q       <= '0;
          data_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign count      = count_q;

endmodule
